// File: rtl/mem_arbiter_if.sv
// Signal bundle for the two-requester memory arbiter: both requester ports plus
// the downstream picorv32-style native memory port.
interface mem_arbiter_if;
  logic        m0_valid;
  logic        m0_instr;
  logic [31:0] m0_addr;
  logic [31:0] m0_wdata;
  logic [3:0]  m0_wstrb;
  logic        m0_ready;
  logic [31:0] m0_rdata;

  logic        m1_valid;
  logic        m1_instr;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic [3:0]  m1_wstrb;
  logic        m1_ready;
  logic [31:0] m1_rdata;

  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  // Arbiter side.
  modport slave (
    input  m0_valid, m0_instr, m0_addr, m0_wdata, m0_wstrb,
    output m0_ready, m0_rdata,
    input  m1_valid, m1_instr, m1_addr, m1_wdata, m1_wstrb,
    output m1_ready, m1_rdata,
    output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  // Environment side: requesters and memory.
  modport master (
    output m0_valid, m0_instr, m0_addr, m0_wdata, m0_wstrb,
    input  m0_ready, m0_rdata,
    output m1_valid, m1_instr, m1_addr, m1_wdata, m1_wstrb,
    input  m1_ready, m1_rdata,
    input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one picorv32 native memory port between two
// requesters, with a per-transaction watchdog that forces completion on a stall.
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus,
  output logic         timeout_err,
  output logic         grant
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } state_t;

  localparam logic [16:0] TIMEOUT_W = 17'(TIMEOUT);

  state_t      state_q, state_d;
  logic        grant_q, grant_d;
  logic [15:0] wdog_q, wdog_d;
  logic        terr_q, terr_d;

  logic        own_sel;
  logic        own_valid;
  logic        own_instr;
  logic [31:0] own_addr;
  logic [31:0] own_wdata;
  logic [3:0]  own_wstrb;
  logic        wdog_hit;
  logic        done;
  logic        forced;
  logic        fwd;
  logic        mem_valid_c;
  logic        resp;
  logic [31:0] rdata;

  assign own_sel   = (state_q == BUSY1);
  assign own_valid = own_sel ? bus.m1_valid : bus.m0_valid;
  assign own_instr = own_sel ? bus.m1_instr : bus.m0_instr;
  assign own_addr  = own_sel ? bus.m1_addr  : bus.m0_addr;
  assign own_wdata = own_sel ? bus.m1_wdata : bus.m0_wdata;
  assign own_wstrb = own_sel ? bus.m1_wstrb : bus.m0_wstrb;

  // The watchdog fires on the stalled cycle that would bring the count to TIMEOUT.
  assign wdog_hit = ({1'b0, wdog_q} + 17'd1) == TIMEOUT_W;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= 1'b1;
      wdog_q  <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      wdog_q  <= wdog_d;
      terr_q  <= terr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    wdog_d      = wdog_q;
    terr_d      = terr_q;
    done        = 1'b0;
    forced      = 1'b0;
    fwd         = 1'b0;
    mem_valid_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.m0_valid || bus.m1_valid) begin
          // On a tie the requester that did not hold the last grant wins.
          grant_d = (bus.m0_valid && bus.m1_valid) ? ~grant_q : bus.m1_valid;
          state_d = grant_d ? BUSY1 : BUSY0;
          wdog_d  = '0;
        end
      end
      BUSY0, BUSY1: begin
        fwd = 1'b1;
        if (!own_valid) begin
          state_d = IDLE;
        end else if (bus.mem_ready) begin
          done        = 1'b1;
          mem_valid_c = 1'b1;
          state_d     = IDLE;
        end else if (wdog_hit) begin
          forced  = 1'b1;
          terr_d  = 1'b1;
          state_d = IDLE;
        end else begin
          mem_valid_c = 1'b1;
          wdog_d      = wdog_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset kills the response in the cycle it is asserted so an abandoned
  // transaction never completes upstream.
  assign resp  = (done | forced) & ~reset;
  assign rdata = (done & ~reset) ? bus.mem_rdata : 32'h0;

  assign bus.mem_valid = mem_valid_c & ~reset;
  assign bus.mem_instr = fwd & own_instr;
  assign bus.mem_addr  = fwd ? own_addr  : 32'h0;
  assign bus.mem_wdata = fwd ? own_wdata : 32'h0;
  assign bus.mem_wstrb = fwd ? own_wstrb : 4'h0;

  assign bus.m0_ready = resp & ~own_sel;
  assign bus.m1_ready = resp & own_sel;
  assign bus.m0_rdata = own_sel ? 32'h0 : rdata;
  assign bus.m1_rdata = own_sel ? rdata : 32'h0;

  assign timeout_err = terr_q;
  assign grant       = grant_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a cycle table of directed corner cases followed by
// randomized traffic checked against a transaction-level reference model.
module tb_mem_arbiter;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic reset;
  logic timeout_err;
  logic grant;

  mem_arbiter_if bus();

  mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .timeout_err(timeout_err),
    .grant      (grant)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string p,
                           input logic r0, input logic [31:0] rd0,
                           input logic r1, input logic [31:0] rd1,
                           input logic mv, input logic mi, input logic [31:0] ma,
                           input logic [31:0] mwd, input logic [3:0] mws,
                           input logic g, input logic te);
    chk({p, " m0_ready"},    32'(bus.m0_ready),   32'(r0));
    chk({p, " m0_rdata"},    bus.m0_rdata,        rd0);
    chk({p, " m1_ready"},    32'(bus.m1_ready),   32'(r1));
    chk({p, " m1_rdata"},    bus.m1_rdata,        rd1);
    chk({p, " mem_valid"},   32'(bus.mem_valid),  32'(mv));
    chk({p, " mem_instr"},   32'(bus.mem_instr),  32'(mi));
    chk({p, " mem_addr"},    bus.mem_addr,        ma);
    chk({p, " mem_wdata"},   bus.mem_wdata,       mwd);
    chk({p, " mem_wstrb"},   32'(bus.mem_wstrb),  32'(mws));
    chk({p, " grant"},       32'(grant),          32'(g));
    chk({p, " timeout_err"}, 32'(timeout_err),    32'(te));
  endtask

  // One row = one clock cycle: inputs applied after the edge, outputs checked mid-cycle.
  typedef struct {
    logic        rst;
    logic        v0;
    logic [31:0] a0;
    logic        v1;
    logic [31:0] a1;
    logic [3:0]  s1;
    logic [31:0] d1;
    logic        mr;
    logic [31:0] md;
    logic        r0;
    logic [31:0] rd0;
    logic        r1;
    logic [31:0] rd1;
    logic        mv;
    logic [31:0] ma;
    logic [3:0]  mws;
    logic [31:0] mwd;
    logic        g;
    logic        te;
  } vec_t;

  function automatic vec_t V(input logic [31:0] rst, v0, a0, v1, a1, s1, d1, mr, md,
                             input logic [31:0] r0, rd0, r1, rd1, mv, ma, mws, mwd, g, te);
    vec_t r;
    r.rst = rst[0]; r.v0 = v0[0]; r.a0 = a0; r.v1 = v1[0]; r.a1 = a1;
    r.s1 = s1[3:0]; r.d1 = d1; r.mr = mr[0]; r.md = md;
    r.r0 = r0[0]; r.rd0 = rd0; r.r1 = r1[0]; r.rd1 = rd1; r.mv = mv[0];
    r.ma = ma; r.mws = mws[3:0]; r.mwd = mwd; r.g = g[0]; r.te = te[0];
    return r;
  endfunction

  vec_t tbl[$];

  // Randomized requester/memory drive state and reference model state.
  logic        rv[2];
  logic        ri[2];
  logic [31:0] ra[2];
  logic [31:0] rw[2];
  logic [3:0]  rs[2];
  logic        exp_rdy[2];
  logic        mr;
  logic [31:0] md;
  int          m_owner;   // -1 when no transaction is in flight
  int          m_grant;
  int          m_stall;
  logic        m_terr;
  int          n_txn;
  int          n_forced;

  task automatic drive_rand();
    bus.m0_valid = rv[0]; bus.m0_instr = ri[0]; bus.m0_addr = ra[0];
    bus.m0_wdata = rw[0]; bus.m0_wstrb = rs[0];
    bus.m1_valid = rv[1]; bus.m1_instr = ri[1]; bus.m1_addr = ra[1];
    bus.m1_wdata = rw[1]; bus.m1_wstrb = rs[1];
    bus.mem_ready = mr;   bus.mem_rdata = md;
  endtask

  // Evaluates one cycle from the rules: outputs expected now, then the model
  // advances to what holds after the coming clock edge.
  task automatic model_cycle(input int cyc);
    logic        er[2];
    logic [31:0] erd[2];
    logic        emv, ei;
    logic [31:0] ea, ewd;
    logic [3:0]  ews;
    int          n_owner, n_grant, n_stall;
    logic        n_terr;
    er = '{1'b0, 1'b0}; erd = '{32'h0, 32'h0};
    emv = 1'b0; ei = 1'b0; ea = 32'h0; ewd = 32'h0; ews = 4'h0;
    n_owner = m_owner; n_grant = m_grant; n_stall = m_stall; n_terr = m_terr;
    if (m_owner >= 0) begin
      ei = ri[m_owner]; ea = ra[m_owner]; ewd = rw[m_owner]; ews = rs[m_owner];
    end
    if (reset) begin
      n_owner = -1; n_grant = 1; n_stall = 0; n_terr = 1'b0;
    end else if (m_owner < 0) begin
      if (rv[0] && rv[1]) n_owner = 1 - m_grant;
      else if (rv[0])     n_owner = 0;
      else if (rv[1])     n_owner = 1;
      if (n_owner >= 0) begin
        n_grant = n_owner; n_stall = 0;
      end
    end else if (!rv[m_owner]) begin
      n_owner = -1;
    end else if (mr) begin
      er[m_owner] = 1'b1; erd[m_owner] = md; emv = 1'b1; n_owner = -1;
    end else if (m_stall + 1 == TO) begin
      er[m_owner] = 1'b1; n_terr = 1'b1; n_owner = -1;
    end else begin
      emv = 1'b1; n_stall = m_stall + 1;
    end
    check_all($sformatf("rand%0d", cyc), er[0], erd[0], er[1], erd[1],
              emv, ei, ea, ewd, ews, m_grant[0], m_terr);
    for (int n = 0; n < 2; n++) begin
      if (er[n]) begin
        n_txn++;
        if (!mr) n_forced++;
        $display("txn cyc=%0d m%0d addr=%h wstrb=%h rdata=%h %s", cyc, n, ra[n], rs[n],
                 erd[n], mr ? "done" : "timeout");
      end
    end
    exp_rdy = er;
    m_owner = n_owner; m_grant = n_grant; m_stall = n_stall; m_terr = n_terr;
  endtask

  initial begin
    // REQ reset / single read / store / timeout / coincident ready / mid-BUSY reset / round-robin
    tbl.push_back(V(1,0,0,0,0,0,0,0,0,                         0,0,0,0,0,0,0,0,1,0));
    tbl.push_back(V(0,1,'h100,0,0,0,0,0,0,                     0,0,0,0,0,0,0,0,1,0));
    tbl.push_back(V(0,1,'h100,0,0,0,0,0,0,                     0,0,0,0,1,'h100,0,0,0,0));
    tbl.push_back(V(0,1,'h100,0,0,0,0,1,'hDEADBEEF,            1,'hDEADBEEF,0,0,1,'h100,0,0,0,0));
    tbl.push_back(V(0,0,0,0,0,0,0,0,0,                         0,0,0,0,0,0,0,0,0,0));
    tbl.push_back(V(0,0,0,0,0,0,0,1,'h55,                      0,0,0,0,0,0,0,0,0,0));
    tbl.push_back(V(0,0,0,1,'h200,3,'h12345678,0,0,            0,0,0,0,0,0,0,0,0,0));
    tbl.push_back(V(0,0,0,1,'h200,3,'h12345678,0,0,            0,0,0,0,1,'h200,3,'h12345678,1,0));
    tbl.push_back(V(0,0,0,1,'h200,3,'h12345678,1,'hA5A5A5A5,   0,0,1,'hA5A5A5A5,1,'h200,3,'h12345678,1,0));
    tbl.push_back(V(0,0,0,0,0,0,0,0,0,                         0,0,0,0,0,0,0,0,1,0));
    tbl.push_back(V(0,1,'h300,0,0,0,0,0,0,                     0,0,0,0,0,0,0,0,1,0));
    for (int k = 0; k < 3; k++)
      tbl.push_back(V(0,1,'h300,0,0,0,0,0,0,                   0,0,0,0,1,'h300,0,0,0,0));
    tbl.push_back(V(0,1,'h300,0,0,0,0,0,0,                     1,0,0,0,0,'h300,0,0,0,0));
    tbl.push_back(V(0,0,0,0,0,0,0,0,0,                         0,0,0,0,0,0,0,0,0,1));
    tbl.push_back(V(1,0,0,0,0,0,0,0,0,                         0,0,0,0,0,0,0,0,0,1));
    tbl.push_back(V(0,0,0,1,'h400,'hF,0,0,0,                   0,0,0,0,0,0,0,0,1,0));
    for (int k = 0; k < 3; k++)
      tbl.push_back(V(0,0,0,1,'h400,'hF,0,0,0,                 0,0,0,0,1,'h400,'hF,0,1,0));
    tbl.push_back(V(0,0,0,1,'h400,'hF,0,1,'hCAFEF00D,          0,0,1,'hCAFEF00D,1,'h400,'hF,0,1,0));
    tbl.push_back(V(0,0,0,0,0,0,0,0,0,                         0,0,0,0,0,0,0,0,1,0));
    tbl.push_back(V(0,0,0,1,'h500,1,'h77,0,0,                  0,0,0,0,0,0,0,0,1,0));
    tbl.push_back(V(0,0,0,1,'h500,1,'h77,0,0,                  0,0,0,0,1,'h500,1,'h77,1,0));
    tbl.push_back(V(1,0,0,1,'h500,1,'h77,1,'h99,               0,0,0,0,0,'h500,1,'h77,1,0));
    tbl.push_back(V(0,0,0,1,'h500,1,'h77,0,0,                  0,0,0,0,0,0,0,0,1,0));
    tbl.push_back(V(0,0,0,0,'h500,1,'h77,0,0,                  0,0,0,0,0,'h500,1,'h77,1,0));
    tbl.push_back(V(0,0,0,0,0,0,0,1,1,                         0,0,0,0,0,0,0,0,1,0));
    tbl.push_back(V(1,1,'h600,1,'h700,0,0,1,'h11,              0,0,0,0,0,0,0,0,1,0));
    tbl.push_back(V(0,1,'h600,1,'h700,0,0,1,'h11,              0,0,0,0,0,0,0,0,1,0));
    for (int k = 0; k < 2; k++) begin
      tbl.push_back(V(0,1,'h600,1,'h700,0,0,1,'h11,            1,'h11,0,0,1,'h600,0,0,0,0));
      tbl.push_back(V(0,1,'h600,1,'h700,0,0,1,'h11,            0,0,0,0,0,0,0,0,0,0));
      tbl.push_back(V(0,1,'h600,1,'h700,0,0,1,'h11,            0,0,1,'h11,1,'h700,0,0,1,0));
      if (k == 0)
        tbl.push_back(V(0,1,'h600,1,'h700,0,0,1,'h11,          0,0,0,0,0,0,0,0,1,0));
    end
    tbl.push_back(V(0,0,0,0,0,0,0,0,0,                         0,0,0,0,0,0,0,0,1,0));

    reset = 1'b1;
    bus.m0_valid = 1'b0; bus.m0_instr = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0; bus.m0_wstrb = '0;
    bus.m1_valid = 1'b0; bus.m1_instr = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0; bus.m1_wstrb = '0;
    bus.mem_ready = 1'b0; bus.mem_rdata = '0;
    @(posedge clk); #1;

    for (int i = 0; i < tbl.size(); i++) begin
      reset         = tbl[i].rst;
      bus.m0_valid  = tbl[i].v0;  bus.m0_addr  = tbl[i].a0;
      bus.m0_instr  = 1'b0;       bus.m0_wdata = 32'h0; bus.m0_wstrb = 4'h0;
      bus.m1_valid  = tbl[i].v1;  bus.m1_addr  = tbl[i].a1;
      bus.m1_instr  = 1'b0;       bus.m1_wdata = tbl[i].d1; bus.m1_wstrb = tbl[i].s1;
      bus.mem_ready = tbl[i].mr;  bus.mem_rdata = tbl[i].md;
      @(negedge clk);
      check_all($sformatf("row%0d", i), tbl[i].r0, tbl[i].rd0, tbl[i].r1, tbl[i].rd1,
                tbl[i].mv, 1'b0, tbl[i].ma, tbl[i].mwd, tbl[i].mws, tbl[i].g, tbl[i].te);
      $display("row %0d rst=%0d v0=%0d v1=%0d mem_ready=%0d -> m0_ready=%0d m1_ready=%0d grant=%0d",
               i, tbl[i].rst, tbl[i].v0, tbl[i].v1, tbl[i].mr, bus.m0_ready, bus.m1_ready, grant);
      @(posedge clk); #1;
    end

    // Randomized phase; first cycle is a reset so the model starts from a known state.
    m_owner = -1; m_grant = 1; m_stall = 0; m_terr = 1'b0;
    n_txn = 0; n_forced = 0;
    exp_rdy = '{1'b0, 1'b0};
    for (int n = 0; n < 2; n++) begin
      rv[n] = 1'b0; ri[n] = 1'b0; ra[n] = '0; rw[n] = '0; rs[n] = '0;
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int n = 0; n < 2; n++) begin
        if (exp_rdy[n] || !rv[n]) begin
          rv[n] = ($urandom_range(0, 2) != 0);
          ri[n] = 1'($urandom_range(0, 1));
          ra[n] = $urandom;
          rw[n] = $urandom;
          rs[n] = 4'($urandom_range(0, 15));
        end else if ($urandom_range(0, 99) == 0) begin
          rv[n] = 1'b0;
        end
      end
      mr = ($urandom_range(0, 3) == 0);
      md = $urandom;
      reset = (cyc == 0) || ($urandom_range(0, 199) == 0);
      drive_rand();
      @(negedge clk);
      model_cycle(cyc);
      @(posedge clk); #1;
    end
    $display("random phase: %0d transactions, %0d forced by watchdog", n_txn, n_forced);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: TIMEOUT, default 1023, downstream cycles allowed per transaction before forced completion; range 1..65535.
REQ-002 Clock and reset: clk input 1, rising-edge clock; reset input 1, synchronous, active-high.
REQ-003 Requester 0 valid/instr/addr/wdata/wstrb: m0_valid input 1, m0_instr input 1, m0_addr input 32, m0_wdata input 32, m0_wstrb input 4; request fields.
REQ-004 Requester 0 response: m0_ready output 1, transaction done; m0_rdata output 32, read data.
REQ-005 Requester 1: m1_* ports, identical names, directions, widths and meaning to m0_*.
REQ-006 Downstream: mem_valid output 1, mem_instr output 1, mem_addr output 32, mem_wdata output 32, mem_wstrb output 4, mem_ready input 1, mem_rdata input 32; picorv32 native memory protocol.
REQ-007 Status: timeout_err output 1, sticky, set by any forced completion; grant output 1, current or last owner index.

Function
REQ-008 Upstream protocol: requester holds valid and all request fields stable until its ready pulses; ready is a single-cycle pulse.
REQ-009 State machine: IDLE, BUSY0, BUSY1; reset enters IDLE.
REQ-010 IDLE: only m0_valid -> BUSY0; only m1_valid -> BUSY1; both -> the index not equal to grant (round-robin); neither -> stay IDLE.
REQ-011 On entering BUSYn, grant <= n; grant is unchanged in IDLE.
REQ-012 BUSYn: mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb combinationally follow mn_*; the non-owner sees ready=0.
REQ-013 IDLE: mem_valid=0, mem_wstrb=0, mem_addr/mem_wdata=0, mem_instr=0.
REQ-014 BUSYn with mem_ready=1: mn_ready=1 same cycle; mn_rdata=mem_rdata same cycle; next state IDLE.
REQ-015 m0_rdata and m1_rdata: equal mem_rdata for the owner whenever its ready is high, 0 otherwise.
REQ-016 Latency: request in IDLE at cycle N -> mem_valid at N+1; mem_ready at cycle M -> IDLE at M+1, so at least one idle cycle separates back-to-back grants.
REQ-017 Watchdog: 16-bit counter cleared on entering BUSYn, incremented each BUSYn cycle with mem_ready=0.
REQ-018 Counter reaching TIMEOUT while mem_ready=0: mn_ready=1 with mn_rdata=32'h00000000 that cycle, mem_valid forced 0 that cycle, timeout_err <= 1, next state IDLE.
REQ-019 mem_ready and counter==TIMEOUT together: normal completion takes priority; timeout_err is unchanged.
REQ-020 Owner drops mn_valid before ready (protocol violation): mem_valid=0 that cycle; next state IDLE; no ready pulse; timeout_err is unchanged.
REQ-021 mem_ready while in IDLE is ignored; neither requester ready pulses.
REQ-022 A new request from the non-owner during BUSYn waits; it is not dropped and is arbitrated in the next IDLE.
REQ-023 Write or read is not distinguished; wstrb passes unchanged, and rdata is forwarded for writes as well.

Reset
REQ-024 Reset: state IDLE, grant=1 (requester 0 wins the first tie), counter 0, timeout_err 0, all ready outputs 0, mem_valid 0.
REQ-025 Reset asserted mid-transaction: abandons it in the same edge; no ready pulse is issued; mem_valid=0 on the next cycle.
REQ-026 timeout_err clears only on reset.

Verification
REQ-027 Single m0 read at 0x100, memory ready 2 cycles later with 0xDEADBEEF -> mem_addr=0x100, m0_ready once, m0_rdata=0xDEADBEEF, m1_ready never.
REQ-028 m0 and m1 both valid continuously after reset, each transaction 1 cycle -> grant sequence 0,1,0,1 with one IDLE cycle between grants.
REQ-029 m1 store wstrb=4'b0011, wdata=0x12345678 -> mem_wstrb=4'b0011, mem_wdata=0x12345678 while BUSY1; m1_ready on mem_ready.
REQ-030 TIMEOUT=4, memory never ready -> m0_ready at the 4th stalled cycle, m0_rdata=0, timeout_err=1, IDLE next cycle.
REQ-031 mem_ready coincides with counter==TIMEOUT -> normal completion, rdata=mem_rdata, timeout_err stays 0.
REQ-032 Reset in mid-BUSY1 -> no m1_ready; IDLE, grant=1, mem_valid=0 on the next cycle.
